// File: rtl/id_hazard_ctrl_if.sv
// ID-stage control/hazard bundle: instruction and pipeline sideband in, ID/EX controls and stall/flush out.
interface id_hazard_ctrl_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        equal_to;
    logic [4:0]  id_ex_rd;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_mem_read;

    logic [1:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        m_branch;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        md_start;
    logic        illegal_instr;
    logic [31:0] stall_cnt;

    modport master (
        output instr, instr_valid, equal_to, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_mem_rd, ex_mem_mem_read,
        input  ex_alu_op, ex_alu_src, m_branch, m_mem_read, m_mem_write, wb_reg_write,
               wb_mem_to_reg, pc_write, if_id_write, if_id_flush, md_start, illegal_instr, stall_cnt
    );

    modport slave (
        input  instr, instr_valid, equal_to, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_mem_rd, ex_mem_mem_read,
        output ex_alu_op, ex_alu_src, m_branch, m_mem_read, m_mem_write, wb_reg_write,
               wb_mem_to_reg, pc_write, if_id_write, if_id_flush, md_start, illegal_instr, stall_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage decoder plus load-use / branch / multi-cycle muldiv hazard control.
// Latency: controls combinational from ID; stall_cnt and muldiv FSM registered. Backpressure: stall freezes PC and IF/ID, bubbles ID/EX.
module id_hazard_ctrl #(
    parameter int MULDIV_EN  = 1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic              clk,
    input logic              rst_n,
    id_hazard_ctrl_if.slave  hz
);
    typedef enum logic {RUN, MD_WAIT} state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    state_t      state, state_nxt;
    logic [3:0]  md_cnt, md_cnt_nxt;
    logic [31:0] stall_cnt_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2;
    logic [3:0]  md_lat;
    ctrl_t       ctrl_dec, ctrl_out;
    logic        legal, is_br, is_md, uses_rs2;
    logic        load_use, branch_dep, stall, issue_md, md_start_c;
    logic        unused_rd;

    assign opcode    = hz.instr[6:0];
    assign funct3    = hz.instr[14:12];
    assign funct7    = hz.instr[31:25];
    assign rs1       = hz.instr[19:15];
    assign rs2       = hz.instr[24:20];
    assign unused_rd = ^hz.instr[11:7];
    assign md_lat    = funct3[2] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);

    always_comb begin
        ctrl_dec = '0;
        legal    = 1'b0;
        is_br    = 1'b0;
        is_md    = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                uses_rs2 = 1'b1;
                is_md    = (funct7 == 7'b0000001);
                legal    = !is_md || (MULDIV_EN != 0);
                ctrl_dec = is_md ? 8'b11_0_0_0_0_1_0 : 8'b10_0_0_0_0_1_0;
            end
            7'b0010011: begin legal = 1'b1; ctrl_dec = 8'b00_1_0_0_0_1_0; end
            7'b0000011: begin legal = 1'b1; ctrl_dec = 8'b00_1_0_1_0_1_1; end
            7'b0100011: begin legal = 1'b1; uses_rs2 = 1'b1; ctrl_dec = 8'b00_1_0_0_1_0_0; end
            7'b1100011: begin
                is_br    = 1'b1;
                uses_rs2 = 1'b1;
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                ctrl_dec = 8'b01_0_1_0_0_0_0;
            end
            default: ;
        endcase
        if (!legal || !hz.instr_valid)
            ctrl_dec = '0;
    end

    // Illegal or empty slots never raise hazards; x0 is never a real dependency.
    always_comb begin
        load_use   = 1'b0;
        branch_dep = 1'b0;
        if (hz.instr_valid && legal) begin
            load_use = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                       ((hz.id_ex_rd == rs1) || (uses_rs2 && hz.id_ex_rd == rs2));
            branch_dep = is_br && (
                (hz.id_ex_reg_write && (hz.id_ex_rd != 5'd0) &&
                    ((hz.id_ex_rd == rs1) || (hz.id_ex_rd == rs2))) ||
                (hz.ex_mem_mem_read && (hz.ex_mem_rd != 5'd0) &&
                    ((hz.ex_mem_rd == rs1) || (hz.ex_mem_rd == rs2))));
        end
    end

    assign stall    = load_use || branch_dep || (state == MD_WAIT);
    assign issue_md = hz.instr_valid && legal && is_md && !stall;

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        md_start_c = 1'b0;
        case (state)
            RUN: begin
                if (issue_md) begin
                    md_start_c = 1'b1;
                    md_cnt_nxt = md_lat - 4'd1;
                    if (md_lat > 4'd1)
                        state_nxt = MD_WAIT;
                end
            end
            MD_WAIT: begin
                md_cnt_nxt = md_cnt - 4'd1;
                if (md_cnt <= 4'd1)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            md_cnt      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        ctrl_out         = '0;
        hz.pc_write      = 1'b0;
        hz.if_id_write   = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.md_start      = 1'b0;
        hz.illegal_instr = 1'b0;
        if (rst_n) begin
            hz.pc_write      = !stall;
            hz.if_id_write   = !stall;
            hz.illegal_instr = hz.instr_valid && !legal && (state == RUN);
            if (!stall) begin
                ctrl_out       = ctrl_dec;
                hz.md_start    = md_start_c;
                hz.if_id_flush = hz.instr_valid && legal && is_br &&
                                 (funct3[0] ? !hz.equal_to : hz.equal_to);
            end
        end
    end

    assign hz.ex_alu_op     = ctrl_out.alu_op;
    assign hz.ex_alu_src    = ctrl_out.alu_src;
    assign hz.m_branch      = ctrl_out.branch;
    assign hz.m_mem_read    = ctrl_out.mem_read;
    assign hz.m_mem_write   = ctrl_out.mem_write;
    assign hz.wb_reg_write  = ctrl_out.reg_write;
    assign hz.wb_mem_to_reg = ctrl_out.mem_to_reg;
    assign hz.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expected outputs queued per step, popped and compared mid-cycle.
module tb_id_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_hazard_ctrl_if bif ();
    id_hazard_ctrl_if bif0 ();

    id_hazard_ctrl #(.MULDIV_EN(1), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .hz(bif.slave));
    id_hazard_ctrl #(.MULDIV_EN(0), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .hz(bif0.slave));

    assign bif0.instr           = bif.instr;
    assign bif0.instr_valid     = bif.instr_valid;
    assign bif0.equal_to        = bif.equal_to;
    assign bif0.id_ex_rd        = bif.id_ex_rd;
    assign bif0.id_ex_reg_write = bif.id_ex_reg_write;
    assign bif0.id_ex_mem_read  = bif.id_ex_mem_read;
    assign bif0.ex_mem_rd       = bif.ex_mem_rd;
    assign bif0.ex_mem_mem_read = bif.ex_mem_mem_read;

    typedef struct {
        logic [7:0]  ctrl;
        logic        pcw, ifw, fl, md, ill;
        logic [31:0] sc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_sc = 0;

    logic [4:0] p_idex_rd = 0, p_exmem_rd = 0;
    logic       p_idex_rw = 0, p_idex_mr = 0, p_exmem_mr = 0;

    localparam logic [7:0] C_R  = 8'b10_0_0_0_0_1_0;
    localparam logic [7:0] C_AI = 8'b00_1_0_0_0_1_0;
    localparam logic [7:0] C_LW = 8'b00_1_0_1_0_1_1;
    localparam logic [7:0] C_SW = 8'b00_1_0_0_1_0_0;
    localparam logic [7:0] C_BR = 8'b01_0_1_0_0_0_0;
    localparam logic [7:0] C_MD = 8'b11_0_0_0_0_1_0;
    localparam logic [7:0] C_0  = 8'b0;

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] itype(logic [6:0] op, logic [11:0] imm, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {imm, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] btype(logic [2:0] f3, logic [4:0] r1, logic [4:0] r2);
        return {7'b0, r2, r1, f3, 5'b0, 7'b1100011};
    endfunction

    task automatic set_sb(logic [4:0] idrd, logic idrw, logic idmr, logic [4:0] emrd, logic emmr);
        p_idex_rd = idrd; p_idex_rw = idrw; p_idex_mr = idmr;
        p_exmem_rd = emrd; p_exmem_mr = emmr;
    endtask

    task automatic cmp(string tag, string fld, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s.%s observed %h expected %h", tag, fld, obs, expv);
        end
    endtask

    task automatic step(string tag, logic rst, logic [31:0] ins, logic vld, logic eq,
                        logic [7:0] e_ctrl, logic e_pcw, logic e_fl, logic e_md, logic e_ill);
        exp_t e;
        logic [7:0] oc;
        @(negedge clk);
        rst_n = rst;
        bif.instr = ins; bif.instr_valid = vld; bif.equal_to = eq;
        bif.id_ex_rd = p_idex_rd; bif.id_ex_reg_write = p_idex_rw; bif.id_ex_mem_read = p_idex_mr;
        bif.ex_mem_rd = p_exmem_rd; bif.ex_mem_mem_read = p_exmem_mr;
        e.ctrl = e_ctrl; e.pcw = e_pcw; e.ifw = e_pcw; e.fl = e_fl;
        e.md = e_md; e.ill = e_ill; e.sc = exp_sc;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        oc = {bif.ex_alu_op, bif.ex_alu_src, bif.m_branch, bif.m_mem_read, bif.m_mem_write,
              bif.wb_reg_write, bif.wb_mem_to_reg};
        cmp(tag, "ctrl", 32'(oc), 32'(e.ctrl));
        cmp(tag, "pc_write", 32'(bif.pc_write), 32'(e.pcw));
        cmp(tag, "if_id_write", 32'(bif.if_id_write), 32'(e.ifw));
        cmp(tag, "if_id_flush", 32'(bif.if_id_flush), 32'(e.fl));
        cmp(tag, "md_start", 32'(bif.md_start), 32'(e.md));
        cmp(tag, "illegal", 32'(bif.illegal_instr), 32'(e.ill));
        cmp(tag, "stall_cnt", bif.stall_cnt, e.sc);
        if (!rst) exp_sc = 0;
        else if (!e.pcw) exp_sc = exp_sc + 1;
    endtask

    logic [31:0] add6, div10, mul10, beq7, lw8, sw, addi, illop;
    logic [7:0]  oc0;

    initial begin
        bif.instr = '0; bif.instr_valid = 0; bif.equal_to = 0;
        bif.id_ex_rd = 0; bif.id_ex_reg_write = 0; bif.id_ex_mem_read = 0;
        bif.ex_mem_rd = 0; bif.ex_mem_mem_read = 0;
        add6  = rtype(7'b0, 5'd1, 5'd5, 3'b000, 5'd6);
        div10 = rtype(7'b0000001, 5'd12, 5'd11, 3'b100, 5'd10);
        mul10 = rtype(7'b0000001, 5'd12, 5'd11, 3'b000, 5'd10);
        beq7  = btype(3'b000, 5'd7, 5'd0);
        lw8   = itype(7'b0000011, 12'd4, 5'd9, 3'b010, 5'd8);
        sw    = {7'b0, 5'd8, 5'd9, 3'b010, 5'b0, 7'b0100011};
        addi  = itype(7'b0010011, 12'd1, 5'd3, 3'b000, 5'd2);
        illop = {12'b0, 5'd5, 3'b0, 5'd4, 7'b1111111};

        step("reset", 0, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("idle", 1, add6, 0, 0, C_0, 1, 0, 0, 0);
        set_sb(5'd5, 1, 1, 5'd0, 0);
        step("lw_use", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        set_sb(5'd0, 0, 0, 5'd0, 0);
        step("lw_use_issue", 1, add6, 1, 0, C_R, 1, 0, 0, 0);
        set_sb(5'd1, 1, 1, 5'd0, 0);
        step("lw_use_rs2", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("addi_no_rs2", 1, addi, 1, 0, C_AI, 1, 0, 0, 0);
        set_sb(5'd0, 1, 1, 5'd0, 0);
        step("rd_x0", 1, rtype(7'b0, 5'd0, 5'd0, 3'b000, 5'd6), 1, 0, C_R, 1, 0, 0, 0);
        set_sb(5'd0, 0, 0, 5'd0, 0);
        step("beq_taken", 1, beq7, 1, 1, C_BR, 1, 1, 0, 0);
        step("bne_eq", 1, btype(3'b001, 5'd7, 5'd0), 1, 1, C_BR, 1, 0, 0, 0);
        step("bne_ne", 1, btype(3'b001, 5'd7, 5'd0), 1, 0, C_BR, 1, 1, 0, 0);
        set_sb(5'd0, 0, 0, 5'd7, 1);
        step("br_ldmem", 1, beq7, 1, 1, C_0, 0, 0, 0, 0);
        set_sb(5'd0, 0, 0, 5'd0, 0);
        step("br_ldmem_go", 1, beq7, 1, 1, C_BR, 1, 1, 0, 0);
        set_sb(5'd7, 1, 0, 5'd0, 0);
        step("br_exdep", 1, beq7, 1, 0, C_0, 0, 0, 0, 0);
        set_sb(5'd0, 0, 0, 5'd7, 0);
        step("br_exdep_go", 1, beq7, 1, 0, C_BR, 1, 0, 0, 0);
        set_sb(5'd0, 0, 0, 5'd0, 0);
        step("lw", 1, lw8, 1, 0, C_LW, 1, 0, 0, 0);
        step("sw", 1, sw, 1, 0, C_SW, 1, 0, 0, 0);
        set_sb(5'd5, 1, 1, 5'd0, 0);
        step("ill_opc", 1, illop, 1, 0, C_0, 1, 0, 0, 1);
        set_sb(5'd0, 0, 0, 5'd0, 0);
        step("ill_br_f3", 1, btype(3'b010, 5'd7, 5'd0), 1, 1, C_0, 1, 0, 0, 1);

        step("reset2", 0, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("div", 1, div10, 1, 0, C_MD, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++)
            step("div_wait", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("div_next", 1, add6, 1, 0, C_R, 1, 0, 0, 0);

        step("mul", 1, mul10, 1, 0, C_MD, 1, 0, 1, 0);
        oc0 = {bif0.ex_alu_op, bif0.ex_alu_src, bif0.m_branch, bif0.m_mem_read,
               bif0.m_mem_write, bif0.wb_reg_write, bif0.wb_mem_to_reg};
        cmp("mul_nomd", "illegal", 32'(bif0.illegal_instr), 32'd1);
        cmp("mul_nomd", "ctrl", 32'(oc0), 32'd0);
        cmp("mul_nomd", "pc_write", 32'(bif0.pc_write), 32'd1);
        cmp("mul_nomd", "md_start", 32'(bif0.md_start), 32'd0);
        for (int i = 0; i < 2; i++)
            step("mul_wait", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("mul_next", 1, add6, 1, 0, C_R, 1, 0, 0, 0);

        step("div2", 1, div10, 1, 0, C_MD, 1, 0, 1, 0);
        step("div2_w1", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("div2_w2", 1, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("div2_rst", 0, add6, 1, 0, C_0, 0, 0, 0, 0);
        step("post_rst", 1, add6, 1, 0, C_R, 1, 0, 0, 0);
        step("post_rst2", 1, add6, 1, 0, C_R, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_EN, default 1, enables RV32M multiply/divide decode.
REQ-002 SHALL have parameter MUL_CYCLES, default 3, range 1..15, EX latency of multiply.
REQ-003 SHALL have parameter DIV_CYCLES, default 8, range 1..15, EX latency of divide.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset. One clock; reset is synchronous and active-low.
REQ-005 SHALL have inputs: instr in 32 ID instruction; instr_valid in 1 ID slot holds a real instruction; equal_to in 1 ID register comparator result.
REQ-006 SHALL have inputs: id_ex_rd in 5, id_ex_reg_write in 1, id_ex_mem_read in 1, ex_mem_rd in 5, ex_mem_mem_read in 1, all pipeline-register sideband.
REQ-007 SHALL have outputs: ex_alu_op out 2, ex_alu_src out 1, m_branch out 1, m_mem_read out 1, m_mem_write out 1, wb_reg_write out 1, wb_mem_to_reg out 1 (ID/EX controls).
REQ-008 SHALL have outputs: pc_write out 1, if_id_write out 1, if_id_flush out 1, md_start out 1 one-cycle muldiv launch, illegal_instr out 1, stall_cnt out 32 saturating stall-cycle counter.

Function
REQ-009 SHALL decode opcode R 0110011, ADDI 0010011, LW 0000011, SW 0100011, BRANCH 1100011; ALU/mem/WB controls per type: R {10,0,0,0,0,1,0}, ADDI {00,1,0,0,0,1,0}, LW {00,1,0,1,0,1,1}, SW {00,1,0,0,1,0,0}, BRANCH {01,0,1,0,0,0,0}; all don't-cares driven 0.
REQ-010 SHALL decode R-type with funct7=0000001 as muldiv when MULDIV_EN=1: ex_alu_op=11, other controls as R; funct3[2]=0 multiply, 1 divide.
REQ-011 SHALL treat unknown opcode, BRANCH funct3 not 000/001, or muldiv with MULDIV_EN=0 as illegal: all controls 0, illegal_instr=1 same cycle, no stall, no flush.
REQ-012 SHALL, when instr_valid=0, drive all controls 0, illegal_instr=0, no hazard, pc_write=1, if_id_write=1.
REQ-013 SHALL flag load_use when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals rs1 (instr[19:15]) or, for R/SW/BRANCH, rs2 (instr[24:20]).
REQ-014 SHALL flag branch_dep for BRANCH when a nonzero matching rs1/rs2 equals id_ex_rd with id_ex_reg_write=1, or ex_mem_rd with ex_mem_mem_read=1.
REQ-015 SHALL compute stall = load_use | branch_dep | (state==MD_WAIT); on stall: pc_write=0, if_id_write=0, all ID/EX controls 0 (bubble), if_id_flush=0, md_start=0.
REQ-016 SHALL, for unstalled BRANCH, assert if_id_flush=1 for that cycle iff taken: BEQ(funct3 000) & equal_to, or BNE(001) & !equal_to.
REQ-017 SHALL implement FSM states RUN, MD_WAIT; reset state RUN.
REQ-018 SHALL in RUN on unstalled valid muldiv: output its controls, md_start=1, load counter with latency-1; go MD_WAIT if latency>1, else stay RUN.
REQ-019 SHALL in MD_WAIT decrement counter each cycle; return to RUN in the cycle after counter reads 1; total bubble cycles = latency-1.
REQ-020 SHALL give MD_WAIT priority over all other hazards; ID instruction held and re-evaluated in RUN.
REQ-021 SHALL increment stall_cnt each cycle stall=1, saturating at 0xFFFFFFFF.
REQ-022 SHALL NOT flag hazards on rd=x0.

Reset
REQ-023 SHALL, on clk edge with rst_n=0, set state RUN, counter 0, stall_cnt 0.
REQ-024 SHALL, while rst_n=0, drive all controls 0, pc_write=0, if_id_write=0, if_id_flush=0, md_start=0, illegal_instr=0.
REQ-025 SHALL abort MD_WAIT on reset with no further stall after release.

Verification
REQ-026 SHALL test LW x5 in EX, ID ADD x6,x5,x1 -> one bubble cycle, pc_write=0, stall_cnt 0->1, ADD issued next cycle.
REQ-027 SHALL test BEQ, equal_to=1, no deps -> if_id_flush=1 one cycle, m_branch=1; BNE equal_to=1 -> flush=0.
REQ-028 SHALL test BEQ rs1=x7 with LW x7 in MEM -> one stall; with ADD x7 in EX -> stall then next cycle resolve.
REQ-029 SHALL test DIV with DIV_CYCLES=8 -> md_start one cycle, 7 bubble cycles, stall_cnt=7, then next instruction issues.
REQ-030 SHALL test MUL with MULDIV_EN=0 -> illegal_instr=1, all controls 0; opcode 1111111 -> illegal_instr=1.
REQ-031 SHALL test rst_n=0 during MD_WAIT cycle 3 -> RUN after release, stall_cnt=0, no residual stall.
